// File: rtl/csa_pkg.sv
// Shared types, default widths and the operand extension helper for the
// carry-save accumulator slice.
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int unsigned DEF_OP_W    = 32;
    localparam int unsigned DEF_GUARD_W = 4;
    localparam int unsigned DEF_CNT_W   = 8;
    localparam int unsigned EXT_MAX_W   = 128;

    // Extends the low w bits of v to EXT_MAX_W; w must be at least 1.
    function automatic logic [EXT_MAX_W-1:0] ext(
        input logic [EXT_MAX_W-1:0] v,
        input int unsigned          w,
        input logic                 sgn
    );
        logic [EXT_MAX_W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < EXT_MAX_W; i++) begin
            if (i >= w) begin
                r[i] = sgn & v[w-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/csa_compress4.sv
// Purely combinational 4:2 compressor built from two cascaded 3:2 CSA levels;
// o_sum + o_carry == a + b + c + d modulo 2^W.
module csa_compress4 #(
    parameter int unsigned W = 36
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    logic [W-1:0] w_s1;
    logic [W-1:0] w_maj1;
    logic [W-1:0] w_c1;
    logic [W-1:0] w_maj2;

    assign w_s1   = i_a ^ i_b ^ i_c;
    assign w_maj1 = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    assign w_c1   = w_maj1 << 1;

    assign o_sum   = w_s1 ^ w_c1 ^ i_d;
    assign w_maj2  = (w_s1 & w_c1) | (w_s1 & i_d) | (w_c1 & i_d);
    assign o_carry = w_maj2 << 1;

endmodule

// File: rtl/csa_accum_pipe.sv
// Pipelined four-operand accumulator: carry-save running total per packet,
// resolved by one carry-propagate add. Optional beat counter: CSA_BEAT_COUNT_EN.
module csa_accum_pipe
    import csa_pkg::*;
#(
    parameter int unsigned OP_W    = DEF_OP_W,
    parameter int unsigned GUARD_W = DEF_GUARD_W,
    parameter int unsigned SIGNED  = 0,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [OP_W-1:0]         in_a,
    input  logic [OP_W-1:0]         in_b,
    input  logic [OP_W-1:0]         in_c,
    input  logic [OP_W-1:0]         in_d,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OP_W+GUARD_W-1:0] out_data
`ifdef CSA_BEAT_COUNT_EN
    ,
    output logic [CNT_W-1:0]        out_beats
`endif
);

    localparam int unsigned ACC_W = OP_W + GUARD_W;
    localparam logic        SGN   = (SIGNED != 0);

    state_t           r_state;
    logic [ACC_W-1:0] r_s1_sum;
    logic [ACC_W-1:0] r_s1_carry;
    logic             r_s1_valid;
    logic             r_s1_last;
    logic [ACC_W-1:0] r_acc_sum;
    logic [ACC_W-1:0] r_acc_carry;
    logic             r_first;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;

    logic             w_fire;
    logic [ACC_W-1:0] w_a;
    logic [ACC_W-1:0] w_b;
    logic [ACC_W-1:0] w_c;
    logic [ACC_W-1:0] w_d;
    logic [ACC_W-1:0] w_st1_sum;
    logic [ACC_W-1:0] w_st1_carry;
    logic [ACC_W-1:0] w_st2_sum;
    logic [ACC_W-1:0] w_st2_carry;

    // Block a new packet while its last beat is still in flight or unresolved.
    assign in_ready  = rst_n && (r_state == ACCUM) && !(r_s1_valid && r_s1_last);
    assign w_fire    = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    assign w_a = ACC_W'(ext(EXT_MAX_W'(in_a), OP_W, SGN));
    assign w_b = ACC_W'(ext(EXT_MAX_W'(in_b), OP_W, SGN));
    assign w_c = ACC_W'(ext(EXT_MAX_W'(in_c), OP_W, SGN));
    assign w_d = ACC_W'(ext(EXT_MAX_W'(in_d), OP_W, SGN));

    csa_compress4 #(.W(ACC_W)) u_stage1 (
        .i_a     (w_a),
        .i_b     (w_b),
        .i_c     (w_c),
        .i_d     (w_d),
        .o_sum   (w_st1_sum),
        .o_carry (w_st1_carry)
    );

    csa_compress4 #(.W(ACC_W)) u_stage2 (
        .i_a     (r_acc_sum),
        .i_b     (r_acc_carry),
        .i_c     (r_s1_sum),
        .i_d     (r_s1_carry),
        .o_sum   (w_st2_sum),
        .o_carry (w_st2_carry)
    );

`ifdef CSA_BEAT_COUNT_EN
    logic [CNT_W-1:0] r_beats;
    logic [CNT_W-1:0] r_out_beats;

    assign out_beats = r_out_beats;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beats     <= '0;
            r_out_beats <= '0;
        end else if (r_state == RESOLVE) begin
            r_out_beats <= r_beats;
            r_beats     <= '0;
        end else if (w_fire && (r_beats != '1)) begin
            r_beats <= r_beats + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ACCUM;
            r_s1_sum    <= '0;
            r_s1_carry  <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_acc_sum   <= '0;
            r_acc_carry <= '0;
            r_first     <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_s1_valid <= w_fire;
            if (w_fire) begin
                r_s1_sum   <= w_st1_sum;
                r_s1_carry <= w_st1_carry;
                r_s1_last  <= in_last;
            end

            case (r_state)
                ACCUM: begin
                    if (r_s1_valid) begin
                        if (r_first) begin
                            r_acc_sum   <= r_s1_sum;
                            r_acc_carry <= r_s1_carry;
                        end else begin
                            r_acc_sum   <= w_st2_sum;
                            r_acc_carry <= w_st2_carry;
                        end
                        r_first <= 1'b0;
                        if (r_s1_last) begin
                            r_state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    r_out_data  <= r_acc_sum + r_acc_carry;
                    r_out_valid <= 1'b1;
                    r_acc_sum   <= '0;
                    r_acc_carry <= '0;
                    r_first     <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_pipe.sv
// Directed bench: three instances (unsigned, signed, no guard bits) share one
// stimulus stream; each result is checked against hand-computed totals.
module tb_csa_accum_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_last;
    logic [31:0] in_a, in_b, in_c, in_d;
    logic        out_ready;

    logic        rdy_u, rdy_s, rdy_g;
    logic        vld_u, vld_s, vld_g;
    logic [35:0] dat_u, dat_s;
    logic [31:0] dat_g;
    logic        all_ready;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

`ifdef CSA_BEAT_COUNT_EN
    logic [7:0]  beats_u, beats_s, beats_g;
`endif

    always #5 clk = ~clk;

    assign all_ready = rdy_u & rdy_s & rdy_g;

    csa_accum_pipe #(.OP_W(32), .GUARD_W(4), .SIGNED(0), .CNT_W(8)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u),
        .in_last(in_last), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(vld_u), .out_ready(out_ready), .out_data(dat_u)
`ifdef CSA_BEAT_COUNT_EN
        , .out_beats(beats_u)
`endif
    );

    csa_accum_pipe #(.OP_W(32), .GUARD_W(4), .SIGNED(1), .CNT_W(8)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
        .in_last(in_last), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(vld_s), .out_ready(out_ready), .out_data(dat_s)
`ifdef CSA_BEAT_COUNT_EN
        , .out_beats(beats_s)
`endif
    );

    csa_accum_pipe #(.OP_W(32), .GUARD_W(0), .SIGNED(0), .CNT_W(8)) u_dut_g (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_g),
        .in_last(in_last), .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(vld_g), .out_ready(out_ready), .out_data(dat_g)
`ifdef CSA_BEAT_COUNT_EN
        , .out_beats(beats_g)
`endif
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the fire edge.
    task automatic send_beat(input logic [31:0] a, b, c, d, input logic last);
        int unsigned waited;
        waited   = 0;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        in_d     = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!all_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_val("in_ready_before_beat", {63'd0, all_ready}, 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Entered at the falling edge right after the last-beat edge k.
    task automatic expect_result(input string tag, input logic [35:0] e_u, input logic [35:0] e_s,
                                 input logic [31:0] e_g, input int unsigned hold, input logic [7:0] e_beats);
        out_ready = (hold == 0);
        check_val({tag, "_rdy_k"}, {63'd0, all_ready}, 64'd0);
        check_val({tag, "_vld_k"}, {61'd0, vld_u, vld_s, vld_g}, 64'd0);
        @(negedge clk);
        check_val({tag, "_vld_k1"}, {61'd0, vld_u, vld_s, vld_g}, 64'd0);
        check_val({tag, "_rdy_k1"}, {63'd0, all_ready}, 64'd0);
        @(negedge clk);
        check_val({tag, "_vld_k2"}, {61'd0, vld_u, vld_s, vld_g}, 64'd7);
        check_val({tag, "_dat_u"}, {28'd0, dat_u}, {28'd0, e_u});
        check_val({tag, "_dat_s"}, {28'd0, dat_s}, {28'd0, e_s});
        check_val({tag, "_dat_g"}, {32'd0, dat_g}, {32'd0, e_g});
`ifdef CSA_BEAT_COUNT_EN
        check_val({tag, "_beats"}, {40'd0, beats_u, beats_s, beats_g}, {40'd0, e_beats, e_beats, e_beats});
`else
        if (e_beats == 8'd0) $display("note: %s expects zero beats", tag);
`endif
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            check_val({tag, "_hold_vld"}, {61'd0, vld_u, vld_s, vld_g}, 64'd7);
            check_val({tag, "_hold_dat"}, {28'd0, dat_u}, {28'd0, e_u});
            check_val({tag, "_hold_rdy"}, {63'd0, all_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_val({tag, "_vld_after_hs"}, {61'd0, vld_u, vld_s, vld_g}, 64'd0);
        check_val({tag, "_rdy_after_hs"}, {63'd0, all_ready}, 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        in_d      = '0;
        out_ready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check_val("reset_vld", {61'd0, vld_u, vld_s, vld_g}, 64'd0);
        check_val("reset_dat", {28'd0, dat_u}, 64'd0);
        check_val("reset_rdy", {63'd0, all_ready}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("idle_rdy", {63'd0, all_ready}, 64'd1);

        send_beat(32'd1, 32'd2, 32'd3, 32'd4, 1'b1);
        expect_result("single", 36'd10, 36'd10, 32'd10, 0, 8'd1);

        // Idle cycle between beats 1 and 2 checks that the accumulator holds.
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        expect_result("three", 36'hBFFFFFFF4, 36'hFFFFFFFF4, 32'hFFFFFFF4, 0, 8'd3);

        send_beat(32'd5, 32'd6, 32'd7, 32'd8, 1'b1);
        expect_result("backpr", 36'd26, 36'd26, 32'd26, 5, 8'd1);

        send_beat(32'hFFFFFFFB, 32'd2, 32'd0, 32'd0, 1'b1);
        expect_result("neg", 36'h0FFFFFFFD, 36'hFFFFFFFFD, 32'hFFFFFFFD, 0, 8'd1);

        send_beat(32'h80000000, 32'h80000000, 32'd0, 32'd0, 1'b1);
        expect_result("wrap", 36'h100000000, 36'hF00000000, 32'd0, 0, 8'd1);

        send_beat(32'd7, 32'd7, 32'd7, 32'd7, 1'b0);
        send_beat(32'd9, 32'd9, 32'd9, 32'd9, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_rdy", {63'd0, all_ready}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("midrst_no_out", {61'd0, vld_u, vld_s, vld_g}, 64'd0);
        end
        send_beat(32'd1, 32'd1, 32'd1, 32'd1, 1'b1);
        expect_result("postrst", 36'd4, 36'd4, 32'd4, 0, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
